ercm_div16_8: RTL and testbench
===============================

// Module: ercm_div16_8
// PURPOSE
//  Sequential restoring divider: 2W-bit dividend / W-bit divisor -> W-bit quotient (+ remainder).
//  Inverse of the 8x8 ERCM multiplier datapath; recovers operands from products for error analysis.
//  Sits beside the multipliers behind a valid/ready handshake; exact arithmetic, one op in flight.
// PARAMETERS
//  W        8   divisor/quotient width; dividend is 2*W bits
//  CNT_W    4   iteration counter width, must be >= $clog2(W+1)
// PORTS
//  clk        in   1     clock, all state updates on rising edge
//  rst        in   1     synchronous reset, active-high
//  dat_in_a   in   2*W   dividend
//  dat_in_b   in   W     divisor
//  in_vld     in   1     operands valid
//  in_rdy     out  1     block can accept operands
//  dat_o      out  W     quotient
//  rem_o      out  W     remainder (only with ERCM_DIV_REM_EN)
//  dz_o       out  1     divide-by-zero flag, valid with out_vld
//  ovf_o      out  1     quotient-overflow flag, valid with out_vld
//  out_vld    out  1     result valid
//  out_rdy    in   1     consumer accepts result
// BEHAVIOUR
//  - Reset: state=IDLE, in_rdy=1, out_vld=0, dat_o=0, rem_o=0, dz_o=0, ovf_o=0, counter=0.
//  - Reset while CALC/DONE aborts the op; the result is discarded and never presented.
//  - FSM IDLE/CALC/DONE. in_rdy = (state==IDLE); no overlap of ops.
//  - Accept = in_vld & in_rdy at edge E0; operands are registered at E0.
//  - At accept: dat_in_b==0 -> DONE, dz_o=1, ovf_o=0, dat_o={W{1}}, rem_o=dat_in_a[W-1:0].
//  - Else dat_in_a[2W-1:W] >= dat_in_b -> DONE, ovf_o=1, dat_o={W{1}}, rem_o=0.
//  - dz takes priority over ovf; both paths have out_vld high 1 cycle after E0.
//  - Else -> CALC, counter=0; each cycle: P={P[W-1:0],next dividend bit}, width W+1;
//    if P>=divisor then P-=divisor, q bit=1; else q bit=0; MSB first; counter++.
//  - After W CALC cycles (edge E0+W) -> DONE; out_vld high W cycles after E0.
//  - DONE: outputs stable while out_vld & ~out_rdy; on out_vld & out_rdy -> IDLE.
//  - in_rdy rises the cycle after the result handshake. Outputs hold last value until the next op.
//  - in_vld when ~in_rdy is ignored, not queued. out_rdy outside DONE is ignored.
//  - Invariant for normal ops: dat_o*dat_in_b + rem == dat_in_a, rem < dat_in_b.
// CONFIGURATION
//  ERCM_DIV_REM_EN defined: rem_o port present and driven as above.
//  Undefined: rem_o port absent; partial remainder stays internal; quotient timing unchanged.
// STRUCTURE
//  Package ercm_div_pkg: state enum (IDLE, CALC, DONE), default W, CNT_W.
//  Sub-module ercm_div_step: combinational single restoring step
//    (P_in, divisor -> P_out, q_bit); instantiated once and reused each CALC cycle.
//  Top: FSM, counter, quotient shift register, flag/output registers.
// TESTING
//  1000/7 (0x03E8/0x07) -> dat_o=142, rem_o=6, flags 0, out_vld exactly 8 cycles after accept.
//  0xFE01/0xFF -> dat_o=0xFF, rem_o=0, ovf_o=0 (largest non-overflow case).
//  0x0100/0x01 -> ovf_o=1, dat_o=0xFF, rem_o=0, out_vld 1 cycle after accept.
//  0x1234/0x00 -> dz_o=1, ovf_o=0, dat_o=0xFF, rem_o=0x34, out_vld 1 cycle after accept.
//  out_rdy low 5 cycles in DONE -> outputs stable; in_vld pulses ignored; IDLE after handshake.
//  rst at CALC cycle 4 -> next cycle all outputs at reset values; next op 0x0064/0x0A -> dat_o=10, rem_o=0.

Source files
------------

// File: rtl/ercm_div_pkg.sv
// Shared definitions for the ERCM restoring divider: FSM state encoding and
// default datapath widths.
package ercm_div_pkg;

  localparam int unsigned DIV_W     = 8;  // divisor / quotient width
  localparam int unsigned DIV_CNT_W = 4;  // iteration counter width, >= $clog2(DIV_W+1)

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ercm_div_step.sv
// Single combinational restoring-division step: compares the shifted partial
// remainder against the divisor and subtracts when it fits.
module ercm_div_step #(
  parameter int unsigned W = 8
) (
  input  logic [W:0]   p_i,    // partial remainder shifted left with next dividend bit
  input  logic [W-1:0] div_i,  // divisor
  output logic [W-1:0] p_o,    // updated partial remainder (always < divisor)
  output logic         q_o     // quotient bit
);

  // Trial subtract; the result is known to fit in W bits whenever it is taken.
  always_comb begin
    q_o = (p_i >= {1'b0, div_i});
    p_o = q_o ? W'(p_i - {1'b0, div_i}) : p_i[W-1:0];
  end

endmodule

// File: rtl/ercm_div16_8.sv
// Sequential restoring divider, 2W-bit dividend / W-bit divisor, one op in
// flight behind valid/ready handshakes. Define ERCM_DIV_REM_EN to expose the
// remainder on rem_o; otherwise the remainder stays internal.
module ercm_div16_8
  import ercm_div_pkg::*;
#(
  parameter int unsigned W     = DIV_W,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [2*W-1:0] dat_in_a,
  input  logic [W-1:0]   dat_in_b,
  input  logic           in_vld,
  output logic           in_rdy,
  output logic [W-1:0]   dat_o,
`ifdef ERCM_DIV_REM_EN
  output logic [W-1:0]   rem_o,
`endif
  output logic           dz_o,
  output logic           ovf_o,
  output logic           out_vld,
  input  logic           out_rdy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     p_q, p_d;      // partial remainder
  logic [W-1:0]     sh_q, sh_d;    // low dividend bits shift out the top, quotient bits enter the bottom
  logic [W-1:0]     div_q, div_d;
  logic [W-1:0]     dat_q, dat_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;
`ifdef ERCM_DIV_REM_EN
  logic [W-1:0]     rem_q, rem_d;
`endif

  logic [W-1:0]     step_p;
  logic             step_q;

  ercm_div_step #(.W(W)) u_step (
    .p_i   ({p_q, sh_q[W-1]}),
    .div_i (div_q),
    .p_o   (step_p),
    .q_o   (step_q)
  );

  // Next-state, datapath and handshake outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    sh_d    = sh_q;
    div_d   = div_q;
    dat_d   = dat_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
`ifdef ERCM_DIV_REM_EN
    rem_d   = rem_q;
`endif
    in_rdy  = (state_q == IDLE);
    out_vld = (state_q == DONE);

    unique case (state_q)
      IDLE: begin
        if (in_vld) begin
          if (dat_in_b == '0) begin
            state_d = DONE;
            dz_d    = 1'b1;
            ovf_d   = 1'b0;
            dat_d   = '1;
`ifdef ERCM_DIV_REM_EN
            rem_d   = dat_in_a[W-1:0];
`endif
          end else if (dat_in_a[2*W-1:W] >= dat_in_b) begin
            state_d = DONE;
            dz_d    = 1'b0;
            ovf_d   = 1'b1;
            dat_d   = '1;
`ifdef ERCM_DIV_REM_EN
            rem_d   = '0;
`endif
          end else begin
            state_d = CALC;
            cnt_d   = '0;
            p_d     = dat_in_a[2*W-1:W];
            sh_d    = dat_in_a[W-1:0];
            div_d   = dat_in_b;
          end
        end
      end
      CALC: begin
        p_d   = step_p;
        sh_d  = {sh_q[W-2:0], step_q};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          dat_d   = {sh_q[W-2:0], step_q};
          dz_d    = 1'b0;
          ovf_d   = 1'b0;
`ifdef ERCM_DIV_REM_EN
          rem_d   = step_p;
`endif
        end
      end
      DONE: begin
        if (out_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      sh_q    <= '0;
      div_q   <= '0;
      dat_q   <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef ERCM_DIV_REM_EN
      rem_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      sh_q    <= sh_d;
      div_q   <= div_d;
      dat_q   <= dat_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
`ifdef ERCM_DIV_REM_EN
      rem_q   <= rem_d;
`endif
    end
  end

  assign dat_o = dat_q;
  assign dz_o  = dz_q;
  assign ovf_o = ovf_q;
`ifdef ERCM_DIV_REM_EN
  assign rem_o = rem_q;
`endif

endmodule

// File: tb/tb_ercm_div16_8.sv
// Directed self-checking bench for ercm_div16_8. Remainder checks are active
// when ERCM_DIV_REM_EN is defined.
module tb_ercm_div16_8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] dat_in_a;
  logic [7:0]  dat_in_b;
  logic        in_vld;
  logic        in_rdy;
  logic [7:0]  dat_o;
`ifdef ERCM_DIV_REM_EN
  logic [7:0]  rem_o;
`endif
  logic        dz_o;
  logic        ovf_o;
  logic        out_vld;
  logic        out_rdy;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned lat;

  ercm_div16_8 dut (
    .clk      (clk),
    .rst      (rst),
    .dat_in_a (dat_in_a),
    .dat_in_b (dat_in_b),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .dat_o    (dat_o),
`ifdef ERCM_DIV_REM_EN
    .rem_o    (rem_o),
`endif
    .dz_o     (dz_o),
    .ovf_o    (ovf_o),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rem(input string tag, input logic [7:0] exp);
`ifdef ERCM_DIV_REM_EN
    chk(tag, {24'd0, rem_o}, {24'd0, exp});
`else
    if (exp === 8'hxx) $display("unreachable %s", tag);
`endif
  endtask

  // Present operands for one accept edge; lat counts further edges until out_vld.
  task automatic run_op(input logic [15:0] a, input logic [7:0] b, output int unsigned n);
    dat_in_a = a;
    dat_in_b = b;
    in_vld   = 1'b1;
    @(posedge clk); #1;
    in_vld   = 1'b0;
    n = 0;
    while (out_vld !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic handshake;
    out_rdy = 1'b1;
    @(posedge clk); #1;
    out_rdy = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    in_vld   = 1'b0;
    out_rdy  = 1'b0;
    dat_in_a = '0;
    dat_in_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_in_rdy",  {31'd0, in_rdy},  32'd1);
    chk("rst_out_vld", {31'd0, out_vld}, 32'd0);
    chk("rst_dat",     {24'd0, dat_o},   32'd0);
    chk("rst_dz",      {31'd0, dz_o},    32'd0);
    chk("rst_ovf",     {31'd0, ovf_o},   32'd0);
    chk_rem("rst_rem", 8'd0);

    // 1000 / 7 = 142 r 6
    run_op(16'h03E8, 8'h07, lat);
    chk("d1000_lat", lat, 32'd8);
    chk("d1000_q",   {24'd0, dat_o}, 32'd142);
    chk("d1000_dz",  {31'd0, dz_o},  32'd0);
    chk("d1000_ovf", {31'd0, ovf_o}, 32'd0);
    chk_rem("d1000_rem", 8'd6);
    handshake();
    chk("hs1_out_vld", {31'd0, out_vld}, 32'd0);
    chk("hs1_in_rdy",  {31'd0, in_rdy},  32'd1);
    chk("hs1_hold_q",  {24'd0, dat_o},   32'd142);

    // Largest non-overflow: 0xFE01 / 0xFF = 0xFF r 0
    run_op(16'hFE01, 8'hFF, lat);
    chk("dfe01_lat", lat, 32'd8);
    chk("dfe01_q",   {24'd0, dat_o}, 32'hFF);
    chk("dfe01_ovf", {31'd0, ovf_o}, 32'd0);
    chk("dfe01_dz",  {31'd0, dz_o},  32'd0);
    chk_rem("dfe01_rem", 8'd0);
    handshake();

    // Overflow: upper half 0x01 >= divisor 0x01
    run_op(16'h0100, 8'h01, lat);
    chk("ovf_lat", lat, 32'd0);
    chk("ovf_q",   {24'd0, dat_o}, 32'hFF);
    chk("ovf_ovf", {31'd0, ovf_o}, 32'd1);
    chk("ovf_dz",  {31'd0, dz_o},  32'd0);
    chk_rem("ovf_rem", 8'd0);
    handshake();

    // Divide by zero: also overflow-like operands, dz wins
    run_op(16'h1234, 8'h00, lat);
    chk("dz_lat", lat, 32'd0);
    chk("dz_q",   {24'd0, dat_o}, 32'hFF);
    chk("dz_dz",  {31'd0, dz_o},  32'd1);
    chk("dz_ovf", {31'd0, ovf_o}, 32'd0);
    chk_rem("dz_rem", 8'h34);
    handshake();

    // out_rdy in IDLE has no effect
    out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1 out_rdy = 1'b0;
    chk("idle_ordy_in_rdy",  {31'd0, in_rdy},  32'd1);
    chk("idle_ordy_out_vld", {31'd0, out_vld}, 32'd0);

    // 20000 / 200 = 100, then stall 5 cycles with ignored in_vld pulses
    run_op(16'h4E20, 8'hC8, lat);
    chk("d20000_lat", lat, 32'd8);
    chk("d20000_q",   {24'd0, dat_o}, 32'd100);
    for (int i = 0; i < 5; i++) begin
      dat_in_a = 16'h0100 + 16'(i);
      dat_in_b = 8'h01;
      in_vld   = 1'b1;
      @(posedge clk); #1;
      chk("stall_out_vld", {31'd0, out_vld}, 32'd1);
      chk("stall_in_rdy",  {31'd0, in_rdy},  32'd0);
      chk("stall_q",       {24'd0, dat_o},   32'd100);
      chk("stall_ovf",     {31'd0, ovf_o},   32'd0);
    end
    in_vld = 1'b0;
    handshake();
    chk("stall_hs_in_rdy", {31'd0, in_rdy}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_no_queue_vld", {31'd0, out_vld}, 32'd0);
    chk("stall_no_queue_q",   {24'd0, dat_o},   32'd100);

    // Reset at CALC cycle 4 aborts the op
    dat_in_a = 16'h03E8;
    dat_in_b = 8'h07;
    in_vld   = 1'b1;
    @(posedge clk); #1;
    in_vld   = 1'b0;
    chk("calc_in_rdy", {31'd0, in_rdy}, 32'd0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_rdy",  {31'd0, in_rdy},  32'd1);
    chk("abort_out_vld", {31'd0, out_vld}, 32'd0);
    chk("abort_q",       {24'd0, dat_o},   32'd0);
    chk("abort_dz",      {31'd0, dz_o},    32'd0);
    chk("abort_ovf",     {31'd0, ovf_o},   32'd0);
    chk_rem("abort_rem", 8'd0);
    repeat (9) @(posedge clk);
    #1;
    chk("abort_never_vld", {31'd0, out_vld}, 32'd0);

    // 100 / 10 = 10 r 0 after the abort
    run_op(16'h0064, 8'h0A, lat);
    chk("d100_lat", lat, 32'd8);
    chk("d100_q",   {24'd0, dat_o}, 32'd10);
    chk("d100_dz",  {31'd0, dz_o},  32'd0);
    chk("d100_ovf", {31'd0, ovf_o}, 32'd0);
    chk_rem("d100_rem", 8'd0);
    handshake();
    chk("d100_hs_in_rdy", {31'd0, in_rdy}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
